// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR write-pending scoreboard.
// NREG architectural registers, AW-bit indices, LAT_W-bit latency counts.
package gpr_pkg;
   localparam int NREG  = 32;
   localparam int AW    = $clog2(NREG);
   localparam int LAT_W = 3;

   typedef logic [AW-1:0]    reg_idx_t;
   typedef logic [LAT_W-1:0] lat_t;
endpackage

// File: rtl/gpr_sb_entry.sv
// One scoreboard entry: pending bit plus result-latency countdown.
// Ports: clk, reset, load_i/lat_i (issue), clr_i (writeback), flush_i,
//        pend_o/cnt_o (registered state).
module gpr_sb_entry
   import gpr_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  lat_t lat_i,
   input  logic clr_i,
   input  logic flush_i,
   output logic pend_o,
   output lat_t cnt_o
);

   logic pend_q, pend_d;
   lat_t cnt_q, cnt_d;

   // flush beats load beats writeback beats countdown
   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         pend_d = 1'b0;
         cnt_d  = '0;
      end else if (load_i) begin
         pend_d = 1'b1;
         cnt_d  = lat_i;
      end else if (clr_i) begin
         pend_d = 1'b0;
         cnt_d  = '0;
      end else if (pend_q && cnt_q != '0) begin
         cnt_d = cnt_q - lat_t'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_o = pend_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/gpr_scoreboard.sv
// Write-pending scoreboard for the 32x32 GPR file: RAW/WAW stall, bypass
// select, writeback/flush clearing. Inputs iss_* (decode), wb_* (retire),
// flush; outputs stall, iss_fire, fwd_rs/rt, pending, stall_cycles.
// Optional macro GPR_SB_STATS_EN enables the saturating stall counter.
module gpr_scoreboard
   import gpr_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            iss_valid,
   input  reg_idx_t        iss_rs,
   input  reg_idx_t        iss_rt,
   input  logic            iss_use_rs,
   input  logic            iss_use_rt,
   input  logic            iss_we,
   input  reg_idx_t        iss_rd,
   input  lat_t            iss_lat,
   output logic            stall,
   output logic            iss_fire,
   output logic            fwd_rs,
   output logic            fwd_rt,
   input  logic            wb_valid,
   input  reg_idx_t        wb_rd,
   input  logic            flush,
   output logic [NREG-1:0] pending,
   output logic [31:0]     stall_cycles
);

   logic [NREG-1:0] pend;
   lat_t            cnt [NREG];

   // r0 is hardwired zero and never tracked
   assign pend[0] = 1'b0;
   assign cnt[0]  = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_ent
      gpr_sb_entry u_ent (
         .clk     (clk),
         .reset   (reset),
         .load_i  (iss_fire & iss_we & (iss_rd == reg_idx_t'(r))),
         .lat_i   (iss_lat),
         .clr_i   (wb_valid & (wb_rd == reg_idx_t'(r))),
         .flush_i (flush),
         .pend_o  (pend[r]),
         .cnt_o   (cnt[r])
      );
   end

   logic rs_pend, rt_pend, raw_rs, raw_rt, waw;

   assign rs_pend = iss_use_rs & (iss_rs != '0) & pend[iss_rs];
   assign rt_pend = iss_use_rt & (iss_rt != '0) & pend[iss_rt];
   assign raw_rs  = rs_pend & (cnt[iss_rs] != '0);
   assign raw_rt  = rt_pend & (cnt[iss_rt] != '0);
   assign waw     = iss_we & (iss_rd != '0) & pend[iss_rd];

   assign stall    = iss_valid & (raw_rs | raw_rt | waw | flush);
   assign iss_fire = iss_valid & ~stall;
   assign fwd_rs   = rs_pend & (cnt[iss_rs] == '0);
   assign fwd_rt   = rt_pend & (cnt[iss_rt] == '0);
   assign pending  = pend;

`ifdef GPR_SB_STATS_EN
   logic [31:0] sc_q, sc_d;

   always_comb begin
      sc_d = sc_q;
      if (stall && sc_q != '1)
         sc_d = sc_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sc_q <= '0;
      else       sc_q <= sc_d;
   end

   assign stall_cycles = sc_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
